// File: rtl/block_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : block_buffer
//  Description : Assembles bus words into Ascon rate blocks and applies
//                0x01/zero padding to the final block of a message.
//  Revision    : 1.0  initial release
// ============================================================================
module block_buffer #(
    parameter int IN_WIDTH    = 32,
    parameter int BLOCK_WIDTH = 128
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  i_clear,
    input  logic                                  i_in_valid,
    output logic                                  o_in_ready,
    input  logic [IN_WIDTH-1:0]                   i_in_data,
    input  logic                                  i_in_last,
    input  logic [$clog2(IN_WIDTH/8+1)-1:0]       i_in_bytes,
    output logic                                  o_out_valid,
    input  logic                                  i_out_ready,
    output logic [BLOCK_WIDTH-1:0]                o_out_data,
    output logic                                  o_out_last,
    output logic [$clog2(BLOCK_WIDTH/8+1)-1:0]    o_out_bytes
);

    localparam int BYTES       = IN_WIDTH / 8;
    localparam int NUM_WORDS   = BLOCK_WIDTH / IN_WIDTH;
    localparam int BLOCK_BYTES = BLOCK_WIDTH / 8;
    localparam int c_CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int c_IBW       = $clog2(BYTES + 1);
    localparam int c_OBW       = $clog2(BLOCK_BYTES + 1);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_OUT  = 2'd1,
        S_PAD  = 2'd2
    } state_t;

    state_t                   r_state;
    logic [c_CNT_W-1:0]       r_cnt;
    logic [BLOCK_WIDTH-1:0]   r_block;
    logic                     r_pending_pad;
    logic                     r_last;
    logic [c_OBW-1:0]         r_bytes;

    state_t                   w_state_nxt;
    logic [c_CNT_W-1:0]       w_cnt_nxt;
    logic [BLOCK_WIDTH-1:0]   w_block_nxt;
    logic                     w_pending_pad_nxt;
    logic                     w_last_nxt;
    logic [c_OBW-1:0]         w_bytes_nxt;

    logic                     w_in_acc;
    logic                     w_out_acc;
    logic [BLOCK_WIDTH-1:0]   w_fill_block;
    int                       w_base;
    int                       w_p;

    assign o_in_ready  = (r_state == S_FILL) && !i_clear;
    assign o_out_valid = (r_state == S_OUT) || (r_state == S_PAD);
    assign o_out_data  = r_block;
    assign o_out_last  = r_last;
    assign o_out_bytes = r_bytes;

    assign w_in_acc  = i_in_valid && o_in_ready;
    assign w_out_acc = o_out_valid && i_out_ready;

    // Block image after writing the incoming word. On a last word every byte
    // from the end of message upward is rewritten, so stale data never leaks.
    always_comb begin
        w_base       = int'(r_cnt) * BYTES;
        w_p          = w_base + int'(i_in_bytes);
        w_fill_block = r_block;
        for (int b = 0; b < BLOCK_BYTES; b++) begin
            if ((b / BYTES) == int'(r_cnt)) begin
                if (!i_in_last || (b < w_p)) begin
                    w_fill_block[8*b +: 8] = i_in_data[8*(b % BYTES) +: 8];
                end else if (b == w_p) begin
                    w_fill_block[8*b +: 8] = 8'h01;
                end else begin
                    w_fill_block[8*b +: 8] = 8'h00;
                end
            end else if (i_in_last && ((b / BYTES) > int'(r_cnt))) begin
                w_fill_block[8*b +: 8] = (b == w_p) ? 8'h01 : 8'h00;
            end
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_block_nxt       = r_block;
        w_pending_pad_nxt = r_pending_pad;
        w_last_nxt        = r_last;
        w_bytes_nxt       = r_bytes;

        if (i_clear) begin
            w_state_nxt       = S_FILL;
            w_cnt_nxt         = '0;
            w_pending_pad_nxt = 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_in_acc) begin
                        w_block_nxt = w_fill_block;
                        if (i_in_last) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = S_OUT;
                            if (w_p < BLOCK_BYTES) begin
                                w_last_nxt  = 1'b1;
                                w_bytes_nxt = c_OBW'(w_p);
                            end else begin
                                // Message ends on a block boundary: a
                                // padding-only block follows this one.
                                w_last_nxt        = 1'b0;
                                w_bytes_nxt       = c_OBW'(BLOCK_BYTES);
                                w_pending_pad_nxt = 1'b1;
                            end
                        end else if (r_cnt == c_CNT_W'(NUM_WORDS - 1)) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = S_OUT;
                            w_last_nxt  = 1'b0;
                            w_bytes_nxt = c_OBW'(BLOCK_BYTES);
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end
                S_OUT: begin
                    if (w_out_acc) begin
                        if (r_pending_pad) begin
                            w_block_nxt       = {{(BLOCK_WIDTH-8){1'b0}}, 8'h01};
                            w_last_nxt        = 1'b1;
                            w_bytes_nxt       = '0;
                            w_pending_pad_nxt = 1'b0;
                            w_state_nxt       = S_PAD;
                        end else begin
                            w_state_nxt = S_FILL;
                        end
                    end
                end
                S_PAD: begin
                    if (w_out_acc) begin
                        w_state_nxt = S_FILL;
                    end
                end
                default: begin
                    w_state_nxt = S_FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_FILL;
            r_cnt         <= '0;
            r_block       <= '0;
            r_pending_pad <= 1'b0;
            r_last        <= 1'b0;
            r_bytes       <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_block       <= w_block_nxt;
            r_pending_pad <= w_pending_pad_nxt;
            r_last        <= w_last_nxt;
            r_bytes       <= w_bytes_nxt;
        end
    end

    a_in_bytes_legal: assert property (
        @(posedge clk) disable iff (!rst_n)
        (w_in_acc && i_in_last) |-> (i_in_bytes <= c_IBW'(BYTES))
    );

endmodule
`default_nettype wire

// File: tb/tb_block_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_block_buffer
//  Description : Scoreboard bench for block_buffer (32/128 and 64/128).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_block_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         i_clear, i_in_valid, i_in_last, i_out_ready;
    logic [31:0]  i_in_data;
    logic [2:0]   i_in_bytes;
    logic         o_in_ready, o_out_valid, o_out_last;
    logic [127:0] o_out_data;
    logic [4:0]   o_out_bytes;

    logic         x_clear, x_in_valid, x_in_last, x_out_ready;
    logic [63:0]  x_in_data;
    logic [3:0]   x_in_bytes;
    logic         x_in_ready, x_out_valid, x_out_last;
    logic [127:0] x_out_data;
    logic [4:0]   x_out_bytes;

    block_buffer #(.IN_WIDTH(32), .BLOCK_WIDTH(128)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_clear(i_clear),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
        .i_in_last(i_in_last), .i_in_bytes(i_in_bytes),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
        .o_out_last(o_out_last), .o_out_bytes(o_out_bytes)
    );

    block_buffer #(.IN_WIDTH(64), .BLOCK_WIDTH(128)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .i_clear(x_clear),
        .i_in_valid(x_in_valid), .o_in_ready(x_in_ready), .i_in_data(x_in_data),
        .i_in_last(x_in_last), .i_in_bytes(x_in_bytes),
        .o_out_valid(x_out_valid), .i_out_ready(x_out_ready), .o_out_data(x_out_data),
        .o_out_last(x_out_last), .o_out_bytes(x_out_bytes)
    );

    typedef struct {
        logic [127:0] data;
        logic         last;
        int           nbytes;
    } exp_t;

    exp_t         sb[$];
    exp_t         sb64[$];
    exp_t         m_e;
    exp_t         m_e64;
    byte unsigned g_msg[$];
    int           n_checks = 0;
    int           n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: cut the byte stream into 16-byte blocks; the final block
    // carries the remainder, then 0x01, then zeros (pad-only if remainder 0).
    task automatic push_model(input int which);
        int           n;
        int           nfull;
        int           rem;
        logic [127:0] blk;
        exp_t         e;
        n     = g_msg.size();
        nfull = n / 16;
        rem   = n % 16;
        for (int b = 0; b < nfull; b++) begin
            blk = '0;
            for (int j = 0; j < 16; j++) blk[8*j +: 8] = g_msg[16*b + j];
            e.data = blk; e.last = 1'b0; e.nbytes = 16;
            if (which == 0) sb.push_back(e); else sb64.push_back(e);
        end
        blk = '0;
        for (int j = 0; j < rem; j++) blk[8*j +: 8] = g_msg[16*nfull + j];
        blk[8*rem +: 8] = 8'h01;
        e.data = blk; e.last = 1'b1; e.nbytes = rem;
        if (which == 0) sb.push_back(e); else sb64.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && !i_clear && o_out_valid && i_out_ready) begin
            check("sb_nonempty", 128'(sb.size() != 0), 128'(1));
            if (sb.size() != 0) begin
                m_e = sb.pop_front();
                check("out_data", o_out_data, m_e.data);
                check("out_last", 128'(o_out_last), 128'(m_e.last));
                check("out_bytes", 128'(o_out_bytes), 128'(m_e.nbytes));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && !x_clear && x_out_valid && x_out_ready) begin
            check("sb64_nonempty", 128'(sb64.size() != 0), 128'(1));
            if (sb64.size() != 0) begin
                m_e64 = sb64.pop_front();
                check("out64_data", x_out_data, m_e64.data);
                check("out64_last", 128'(x_out_last), 128'(m_e64.last));
                check("out64_bytes", 128'(x_out_bytes), 128'(m_e64.nbytes));
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (!o_in_ready && t < 200) begin
            @(posedge clk); #1; t++;
        end
        if (!o_in_ready) check("idle_timeout", 128'(o_in_ready), 128'(1));
    endtask

    task automatic send_word(input logic [31:0] d, input logic l, input logic [2:0] nb);
        wait_idle();
        i_in_valid = 1'b1; i_in_data = d; i_in_last = l; i_in_bytes = nb;
        @(posedge clk); #1;
        i_in_valid = 1'b0; i_in_last = 1'b0; i_in_bytes = '0;
    endtask

    task automatic send64(input logic [63:0] d, input logic l, input logic [3:0] nb);
        int t = 0;
        while (!x_in_ready && t < 200) begin
            @(posedge clk); #1; t++;
        end
        if (!x_in_ready) check("in64_timeout", 128'(x_in_ready), 128'(1));
        x_in_valid = 1'b1; x_in_data = d; x_in_last = l; x_in_bytes = nb;
        @(posedge clk); #1;
        x_in_valid = 1'b0; x_in_last = 1'b0; x_in_bytes = '0;
    endtask

    // Unused bytes of the last word carry 0xAA so masking is exercised.
    task automatic send_msg();
        int          n;
        int          nw;
        logic [31:0] d;
        logic        l;
        n  = g_msg.size();
        nw = (n == 0) ? 1 : (n + 3) / 4;
        for (int k = 0; k < nw; k++) begin
            d = 32'hAAAAAAAA;
            for (int j = 0; j < 4; j++)
                if (4*k + j < n) d[8*j +: 8] = g_msg[4*k + j];
            l = (k == nw - 1);
            send_word(d, l, l ? 3'(n - 4*k) : 3'd4);
        end
    endtask

    task automatic fill_msg(input int n);
        g_msg.delete();
        for (int i = 0; i < n; i++) g_msg.push_back(8'($urandom));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 128'(o_out_valid), 128'(0));
        check({tag, "_in_ready"},  128'(o_in_ready),  128'(1));
        check({tag, "_out_data"},  o_out_data,        128'(0));
        check({tag, "_out_last"},  128'(o_out_last),  128'(0));
        check({tag, "_out_bytes"}, 128'(o_out_bytes), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lens[6];
        byte unsigned pat[7];
        logic [63:0] d0, d1;
        lens = '{1, 3, 15, 16, 17, 33};
        pat  = '{8'h00, 8'h11, 8'h22, 8'h33, 8'hDD, 8'hCC, 8'hBB};

        rst_n = 1'b0; i_clear = 1'b0; i_in_valid = 1'b0; i_in_last = 1'b0;
        i_in_data = '0; i_in_bytes = '0; i_out_ready = 1'b1;
        x_clear = 1'b0; x_in_valid = 1'b0; x_in_last = 1'b0;
        x_in_data = '0; x_in_bytes = '0; x_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // Full 32-byte message: two data blocks then a pad-only block.
        g_msg.delete();
        for (int i = 0; i < 32; i++) g_msg.push_back(8'(i));
        push_model(0); send_msg();

        // Partial final block behind a full one clears stale upper words.
        fill_msg(24); push_model(0); send_msg();

        g_msg.delete();
        for (int i = 0; i < 7; i++) g_msg.push_back(pat[i]);
        push_model(0); send_msg();

        // Empty message: pad block visible the cycle after the accept.
        g_msg.delete();
        push_model(0); send_msg();
        check("empty_latency", 128'(o_out_valid), 128'(1));
        check("empty_in_ready", 128'(o_in_ready), 128'(0));

        foreach (lens[i]) begin
            fill_msg(lens[i]); push_model(0); send_msg();
        end

        // Back-pressure: block held steady, input ignored.
        wait_idle();
        i_out_ready = 1'b0;
        fill_msg(11); push_model(0); send_msg();
        for (int c = 0; c < 10; c++) begin
            i_in_valid = 1'b1; i_in_data = $urandom; i_in_last = 1'b1; i_in_bytes = 3'd2;
            check("bp_data", o_out_data, sb[0].data);
            check("bp_last", 128'(o_out_last), 128'(sb[0].last));
            check("bp_bytes", 128'(o_out_bytes), 128'(sb[0].nbytes));
            check("bp_in_ready", 128'(o_in_ready), 128'(0));
            @(posedge clk); #1;
        end
        i_in_valid = 1'b0; i_in_last = 1'b0; i_in_bytes = '0;
        i_out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_fill_next", 128'(o_in_ready), 128'(1));

        // Clear after two words: only the fresh message appears.
        send_word(32'h99999999, 1'b0, 3'd0);
        send_word(32'h88888888, 1'b0, 3'd0);
        i_clear = 1'b1; i_in_valid = 1'b1; i_in_data = 32'h77777777;
        #1;
        check("clr_in_ready", 128'(o_in_ready), 128'(0));
        @(posedge clk); #1;
        i_clear = 1'b0; i_in_valid = 1'b0;
        fill_msg(16); push_model(0); send_msg();

        // Clear during an output handshake: block dropped, not consumed.
        wait_idle();
        i_out_ready = 1'b0;
        fill_msg(8); push_model(0); send_msg();
        i_clear = 1'b1; i_out_ready = 1'b1;
        @(posedge clk); #1;
        i_clear = 1'b0;
        check("clr_valid_drop", 128'(o_out_valid), 128'(0));
        check("clr_sb_held", 128'(sb.size()), 128'(1));
        if (sb.size() != 0) void'(sb.pop_front());

        // 64-bit words, message on a block boundary: data block + pad block.
        fill_msg(16); push_model(1);
        for (int j = 0; j < 8; j++) begin
            d0[8*j +: 8] = g_msg[j];
            d1[8*j +: 8] = g_msg[8 + j];
        end
        send64(d0, 1'b0, 4'd0);
        send64(d1, 1'b1, 4'd8);
        repeat (6) begin @(posedge clk); #1; end

        // Async reset while holding a block with a pad pending.
        wait_idle();
        i_out_ready = 1'b0;
        send_word(32'h03020100, 1'b0, 3'd0);
        send_word(32'h07060504, 1'b0, 3'd0);
        send_word(32'h0B0A0908, 1'b0, 3'd0);
        send_word(32'h0F0E0D0C, 1'b1, 3'd4);
        check("rst_pre_valid", 128'(o_out_valid), 128'(1));
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        i_out_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        check("rst_no_pad", 128'(o_out_valid), 128'(0));

        repeat (4) begin @(posedge clk); #1; end
        check("sb_drained", 128'(sb.size()), 128'(0));
        check("sb64_drained", 128'(sb64.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/block_buffer.md
# block_buffer

Parametrised input buffer for the Ascon-AEAD128 datapath. It accepts bus-width data words over a valid/ready handshake and assembles them little-endian into full rate blocks. It applies SP 800-232 padding (0x01 byte, then zeros) to the final block and emits an extra padding-only block when the message ends on a block boundary. It sits between the host data interface and the permutation/absorb logic, replacing plain enable registers on that path.

## Interface

Parameters:
- IN_WIDTH, 32, input word width in bits; multiple of 8.
- BLOCK_WIDTH, 128, rate block width in bits; multiple of IN_WIDTH.
- Derived (localparams, not overridable): BYTES = IN_WIDTH/8; NUM_WORDS = BLOCK_WIDTH/IN_WIDTH; BLOCK_BYTES = BLOCK_WIDTH/8.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; one clock, reset asynchronous, active-low.
- clear  input  1  synchronous abort; discards any partial or held block.
- in_valid  input  1  in_data/in_last/in_bytes are valid.
- in_ready  output  1  buffer accepts a word this cycle.
- in_data  input  IN_WIDTH  data word; byte j at bits [8j+7:8j].
- in_last  input  1  word is the final word of the message.
- in_bytes  input  $clog2(BYTES+1)  valid bytes in a last word, 0..BYTES; ignored when in_last=0.
- out_valid  output  1  out_data holds a complete block.
- out_ready  input  1  consumer takes the block this cycle.
- out_data  output  BLOCK_WIDTH  assembled block; word i at bits [i*IN_WIDTH +: IN_WIDTH].
- out_last  output  1  block is the final (padded) block of the message.
- out_bytes  output  $clog2(BLOCK_BYTES+1)  message bytes in block, 0..BLOCK_BYTES.

## Operation

- States: FILL, OUT, PAD. Registers: word counter cnt (0..NUM_WORDS-1), block register, pending_pad flag.
- in_ready = (state==FILL) && !clear. out_valid = (state==OUT || state==PAD).
- Input accept = in_valid && in_ready. Output accept = out_valid && out_ready.
- FILL, accept with in_last=0:
  - Write in_data to word cnt.
  - If cnt==NUM_WORDS-1: go to OUT, out_last=0, out_bytes=BLOCK_BYTES, cnt=0.
  - Otherwise cnt+1.
- FILL, accept with in_last=1: let p = cnt*BYTES + in_bytes.
  - Write bytes 0..in_bytes-1 of in_data to word cnt.
  - If p<BLOCK_BYTES: byte p=0x01, all bytes above p=0 (including stale bytes of the current word); go to OUT, out_last=1, out_bytes=p.
  - If p==BLOCK_BYTES: go to OUT, out_last=0, out_bytes=BLOCK_BYTES, pending_pad=1.
  - cnt=0 in both cases.
- OUT, output accept:
  - If pending_pad: load block = 0x01 in byte 0, zeros elsewhere; out_last=1, out_bytes=0; clear pending_pad; go to PAD.
  - Otherwise go to FILL.
- PAD, output accept: go to FILL.
- clear=1 (highest priority, any state): state=FILL, cnt=0, pending_pad=0, out_valid drops next cycle. Input and output handshakes in that cycle are not performed.
- in_bytes>BYTES with in_last=1 is illegal; behaviour is undefined and may be flagged by an assertion.
- in_last with in_bytes=0 at cnt=0 (empty message) yields block 0x01 followed by zeros, out_last=1, out_bytes=0.

## Timing

- Reset values: state=FILL, cnt=0, pending_pad=0, block register=0, out_valid=0, out_last=0, out_bytes=0, in_ready=1 (when clear=0).
- Latency: out_valid rises the cycle after the word completing the block is accepted; registered, with no combinational in→out path.
- No accept/emit overlap: in_ready=0 throughout OUT/PAD. Peak throughput is one block per NUM_WORDS+1 cycles.
- out_data, out_last and out_bytes are stable while out_valid=1 and out_ready=0.
- OUT→PAD swaps the block in the accept cycle; out_valid stays high with no bubble.
- Reset asserted mid-message returns all state immediately to reset values.

## Test plan

- Full message, default params: words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, then 4 more with last word in_last=1, in_bytes=4 → block0 = 0x0F0E…0100, out_last=0; block1 out_last=0; then padding block 0x…0001, out_last=1, out_bytes=0.
- Partial last block: 2 words, second word in_last=1, in_bytes=3, data 0xAABBCCDD → out_data bytes 4..6 = DD,CC,BB; byte 7 = 0x01; bytes 8..15 = 0; out_bytes=7, out_last=1.
- Empty message: in_last=1, in_bytes=0 at cnt=0 → out_data=128'h1, out_bytes=0, out_last=1, one cycle later.
- Back-pressure: hold out_ready=0 for 10 cycles with a block held → out_data/out_last/out_bytes constant, in_ready=0, in_valid ignored; release → FILL next cycle.
- clear mid-fill after 2 words, then a fresh 4-word message → output equals only the new 4 words; clear while out_valid=1 and out_ready=1 → block not counted as consumed, out_valid=0 next cycle.
- Async reset asserted mid-cycle while in OUT with pending_pad=1 → out_valid=0 immediately, no padding block after release; repeat with IN_WIDTH=64, BLOCK_WIDTH=128 for a 2-word message with in_bytes=8 → extra padding block emitted.
